// File: rtl/nibble_serial_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : addsub_pkg
// Purpose  : Shared definitions for the nibble-serial add/subtract unit:
//            FSM state encoding, slice width and saturation helpers.
// Ports    : none (package)
// Options  : ADDSUB_SATURATE_EN (consumer of SAT_MAX / SAT_MIN)
// Revision : 1.0 - initial release
// ============================================================================
package addsub_pkg;

    // Width of the single carry-lookahead slice that is reused every pass.
    localparam int NIBBLE_W = 4;

    // Widest operand the saturation helpers can describe.
    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Largest positive two's-complement value of a width-bit word (0111..1),
    // returned right-aligned in a MAX_WIDTH container.
    function automatic logic [MAX_WIDTH-1:0] SAT_MAX(input int width);
        return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
    endfunction

    // Most negative two's-complement value of a width-bit word (1000..0).
    function automatic logic [MAX_WIDTH-1:0] SAT_MIN(input int width);
        return MAX_WIDTH'(1) << (width - 1);
    endfunction

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/nibble_serial_addsub_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_addsub_if
// Purpose  : Operand / result handshake bundle of the nibble-serial
//            add/subtract unit.
// Signals  : in_valid/in_ready + a, b, sub      (operand side)
//            out_valid/out_ready + sum, cout, overflow (result side)
// Modports : master - operand producer / result consumer
//            slave  - the arithmetic unit
// Revision : 1.0 - initial release
// ============================================================================
interface nibble_serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface : nibble_serial_addsub_if
`default_nettype wire

// File: rtl/nibble_serial_addsub_cla_nibble.sv
`default_nettype none
// ============================================================================
// Module   : cla_nibble
// Purpose  : Combinational 4-bit generate/propagate carry-lookahead adder.
// Ports    : a, b  [3:0] in  - addends
//            cin         in  - carry in
//            sum   [3:0] out - a + b + cin (low 4 bits)
//            cout        out - carry out of bit 3
//            c3          out - carry into bit 3 (for signed overflow)
// Revision : 1.0 - initial release
// ============================================================================
module cla_nibble
    import addsub_pkg::*;
(
    input  wire logic [NIBBLE_W-1:0] a,
    input  wire logic [NIBBLE_W-1:0] b,
    input  wire logic                cin,
    output logic      [NIBBLE_W-1:0] sum,
    output logic                     cout,
    output logic                     c3
);
    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is expanded directly from cin so no ripple path exists.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[NIBBLE_W-1:0];
    assign cout = c[4];
    assign c3   = c[3];

endmodule : cla_nibble
`default_nettype wire

// File: rtl/nibble_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_addsub
// Purpose  : Multi-cycle signed/unsigned add/subtract of WIDTH-bit operands
//            using one 4-bit carry-lookahead slice, LSB nibble first.
//            Result appears WIDTH/4 cycles after operand acceptance.
// Ports    : clk  in  - rising-edge clock
//            rst  in  - asynchronous active-high reset
//            bus  slave modport of nibble_serial_addsub_if:
//                 in_valid/in_ready, a, b, sub     (operands)
//                 out_valid/out_ready, sum, cout, overflow (result)
// Params   : WIDTH - operand width, multiple of 4 and at least 4
// Options  : ADDSUB_SATURATE_EN - clamp an overflowed result to the signed
//            max/min; otherwise the result wraps modulo 2^WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    nibble_serial_addsub_if.slave bus
);
    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

`ifdef ADDSUB_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX_VAL = WIDTH'(SAT_MAX(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN_VAL = WIDTH'(SAT_MIN(WIDTH));
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_lat;
    logic [WIDTH-1:0]   b_lat;      // already inverted when subtracting
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               overflow_q;

    logic               in_ready_c;
    logic               out_valid_c;

    // ------------------------------------------------------------------
    // Nibble mux feeding the single adder slice
    // ------------------------------------------------------------------
    logic [NIBBLE_W-1:0] a_nibs [NIB];
    logic [NIBBLE_W-1:0] b_nibs [NIB];
    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;
    logic                slice_c3;
    logic                slice_ovf;

    for (genvar n = 0; n < NIB; n++) begin : g_split
        assign a_nibs[n] = a_lat[n*NIBBLE_W +: NIBBLE_W];
        assign b_nibs[n] = b_lat[n*NIBBLE_W +: NIBBLE_W];
    end

    assign slice_a = a_nibs[idx];
    assign slice_b = b_nibs[idx];

    cla_nibble u_cla (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

    // Only meaningful on the MSB pass: carry into the sign bit differs
    // from carry out of it.
    assign slice_ovf = slice_c3 ^ slice_cout;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                // No acceptance in this cycle: the unit returns to IDLE
                // first, which bounds throughput at NIB+2 cycles.
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_lat      <= '0;
            b_lat      <= '0;
            carry      <= 1'b0;
            idx        <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtraction is A + ~B + 1: invert B once here and
                        // seed the carry with the +1.
                        a_lat <= bus.a;
                        b_lat <= bus.b ^ {WIDTH{bus.sub}};
                        carry <= bus.sub;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    for (int n = 0; n < NIB; n++) begin
                        if (idx == IDX_W'(n)) begin
                            sum_q[n*NIBBLE_W +: NIBBLE_W] <= slice_sum;
                        end
                    end
                    carry <= slice_cout;
                    if (idx == LAST_IDX) begin
                        idx        <= '0;
                        cout_q     <= slice_cout;
                        overflow_q <= slice_ovf;
`ifdef ADDSUB_SATURATE_EN
                        // Overflow is only possible when both effective
                        // operands share A's sign, so A's sign tells the
                        // direction of the true result. Overrides the
                        // nibble write above.
                        if (slice_ovf) begin
                            sum_q <= a_lat[WIDTH-1] ? SAT_MIN_VAL : SAT_MAX_VAL;
                        end
`endif
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                    // DONE: result held until the consumer takes it.
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = overflow_q;

endmodule : nibble_serial_addsub
`default_nettype wire

// File: tb/tb_nibble_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_addsub
// Purpose  : Self-checking bench for nibble_serial_addsub (WIDTH=8) against
//            an integer-arithmetic reference model.
// Options  : ADDSUB_SATURATE_EN - expected results clamp on signed overflow
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_addsub;
    localparam int WIDTH = 8;
    localparam int NIB   = WIDTH / 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    nibble_serial_addsub_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: returns {overflow, cout, sum} from plain integer arithmetic.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic sub);
        int ua, ub, sa, sb, res_u, res_s;
        logic [WIDTH-1:0] s;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!sub) begin
            res_u = ua + ub;
            c     = (res_u >= 2**WIDTH);
            res_s = sa + sb;
        end else begin
            res_u = ua - ub;
            c     = (ua >= ub);
            res_s = sa - sb;
        end
        s = WIDTH'(res_u);
        v = (res_s > 2**(WIDTH-1) - 1) || (res_s < -(2**(WIDTH-1)));
`ifdef ADDSUB_SATURATE_EN
        if (v) s = (res_s > 0) ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
        return {v, c, s};
    endfunction

    // Drives one full transaction and reports what the DUT produced.
    // lat = clock edges from the accepting edge until out_valid is seen.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sub, output logic [WIDTH-1:0] s,
                          output logic c, output logic v, output int lat);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.sub = sub;
        @(posedge clk); #1;
        // Scramble operands after acceptance; they must be ignored.
        bus.in_valid = 1'b0;
        bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.sub = 1'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        s = bus.sum; c = bus.cout; v = bus.overflow;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.sum !== '0) begin failures++; $display("FAIL reset_sum: got %h expected 00", bus.sum); end
        checks++; if (bus.cout !== 1'b0) begin failures++; $display("FAIL reset_cout: got %b expected 0", bus.cout); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] ta [5] = '{8'h3C, 8'h7F, 8'hFF, 8'h10, 8'h80};
        logic [WIDTH-1:0] tb_ [5] = '{8'h25, 8'h01, 8'h01, 8'h20, 8'h01};
        logic             tsub [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef ADDSUB_SATURATE_EN
        logic [WIDTH-1:0] tsum [5] = '{8'h61, 8'h7F, 8'h00, 8'hF0, 8'h80};
`else
        logic [WIDTH-1:0] tsum [5] = '{8'h61, 8'h80, 8'h00, 8'hF0, 8'h7F};
`endif
        logic             tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic             tv [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [WIDTH-1:0] s;
        logic c, v;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb_[i], tsub[i], s, c, v, lat);
            checks++; if (s !== tsum[i]) begin failures++; $display("FAIL directed_sum[%0d]: got %h expected %h", i, s, tsum[i]); end
            checks++; if (c !== tc[i]) begin failures++; $display("FAIL directed_cout[%0d]: got %b expected %b", i, c, tc[i]); end
            checks++; if (v !== tv[i]) begin failures++; $display("FAIL directed_overflow[%0d]: got %b expected %b", i, v, tv[i]); end
            checks++; if (lat != NIB) begin failures++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, NIB); end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b, s, es;
        logic sub, c, v, ec, ev;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom);
            {ev, ec, es} = model(a, b, sub);
            run_op(a, b, sub, s, c, v, lat);
            checks++; if (s !== es) begin failures++; $display("FAIL random_sum a=%h b=%h sub=%b: got %h expected %h", a, b, sub, s, es); end
            checks++; if (c !== ec) begin failures++; $display("FAIL random_cout a=%h b=%h sub=%b: got %b expected %b", a, b, sub, c, ec); end
            checks++; if (v !== ev) begin failures++; $display("FAIL random_overflow a=%h b=%h sub=%b: got %b expected %b", a, b, sub, v, ev); end
            checks++; if (lat != NIB) begin failures++; $display("FAIL random_latency: got %0d expected %0d", lat, NIB); end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] a, b, es, s;
        logic sub, ec, ev, c, v;
        int n, lat, seen;
        a = 8'h9A; b = 8'h47; sub = 1'b1;
        {ev, ec, es} = model(a, b, sub);
        n = 0;
        while (!bus.in_ready && n < 20) begin @(posedge clk); #1; n++; end
        bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.sub = sub;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != NIB) begin failures++; $display("FAIL bp_latency: got %0d expected %0d", lat, NIB); end
        for (int i = 0; i < 5; i++) begin
            // New operands offered while busy must not disturb anything.
            bus.in_valid = 1'b1; bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.sub = 1'($urandom);
            @(posedge clk); #1;
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, bus.out_valid); end
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
            checks++; if ({bus.overflow, bus.cout, bus.sum} !== {ev, ec, es}) begin failures++;
                $display("FAIL bp_hold[%0d]: got %b%b_%h expected %b%b_%h", i, bus.overflow, bus.cout, bus.sum, ev, ec, es); end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready: got %b expected 1", bus.in_ready); end
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL bp_not_queued: got %0d valid cycles expected 0", seen); end
        a = 8'h55; b = 8'hAA; sub = 1'b0;
        {ev, ec, es} = model(a, b, sub);
        run_op(a, b, sub, s, c, v, lat);
        checks++; if ({v, c, s} !== {ev, ec, es}) begin failures++; $display("FAIL bp_next_op: got %b%b_%h expected %b%b_%h", v, c, s, ev, ec, es); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] a, b, es;
        logic sub, ec, ev;
        int n, lat;
        realtime t_prev, t_now;
        t_prev = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom);
            {ev, ec, es} = model(a, b, sub);
            bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.sub = sub;
            n = 0;
            while (!bus.in_ready && n < 20) begin @(posedge clk); #1; n++; end
            @(posedge clk); #1;
            t_now = $realtime;
            if (k > 0) begin
                checks++; if (int'((t_now - t_prev) / 10.0) != NIB + 2) begin failures++;
                    $display("FAIL b2b_interval[%0d]: got %0d expected %0d", k, int'((t_now - t_prev) / 10.0), NIB + 2); end
            end
            t_prev = t_now;
            lat = 0;
            while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
            checks++; if ({bus.overflow, bus.cout, bus.sum} !== {ev, ec, es}) begin failures++;
                $display("FAIL b2b_result[%0d]: got %b%b_%h expected %b%b_%h", k, bus.overflow, bus.cout, bus.sum, ev, ec, es); end
            if (k == 3) bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [WIDTH-1:0] s, es;
        logic c, v, ec, ev;
        int n, lat, seen;
        n = 0;
        while (!bus.in_ready && n < 20) begin @(posedge clk); #1; n++; end
        bus.in_valid = 1'b1; bus.a = 8'h7F; bus.b = 8'h01; bus.sub = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if ({bus.overflow, bus.cout, bus.sum} !== '0) begin failures++;
            $display("FAIL midrst_outputs: got %b%b_%h expected 00_00", bus.overflow, bus.cout, bus.sum); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready: got %b expected 1", bus.in_ready); end
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL midrst_stale: got %0d valid cycles expected 0", seen); end
        {ev, ec, es} = model(8'h10, 8'h20, 1'b1);
        run_op(8'h10, 8'h20, 1'b1, s, c, v, lat);
        checks++; if ({v, c, s} !== {ev, ec, es}) begin failures++; $display("FAIL midrst_next_op: got %b%b_%h expected %b%b_%h", v, c, s, ev, ec, es); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_nibble_serial_addsub
`default_nettype wire
